// File: rtl/alt_vip_common_stream_output_pkg.sv
// Shared constants for the VIP stream output adapter.
//   STATE_*    : packet-boundary state encoding
//   FIFO_DEPTH : number of buffered words ahead of the output register
//   FIFO_CNT_W : width of the FIFO occupancy count (0..FIFO_DEPTH)
package alt_vip_common_stream_pkg;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] STATE_IDLE   = 1'b0;
  localparam logic [STATE_W-1:0] STATE_PACKET = 1'b1;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/alt_vip_common_stream_output_if.sv
// Avalon-ST style word stream with packet framing.
//   valid/ready : handshake (ready direction opposite to the payload)
//   data        : DATA_WIDTH payload
//   sop/eop     : start / end of packet markers
// master drives the payload, slave drives ready.
interface alt_vip_common_stream_output_if #(
  parameter int unsigned DATA_WIDTH = 10
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);

endinterface

// File: rtl/alt_vip_common_stream_output_fifo.sv
// Two-entry register FIFO; entry0 is always the head.
//   clk, rst : clock, async active-high reset
//   push/din : write a word (ignored when full)
//   pop      : drop the head (ignored when empty)
//   head     : current head word
//   count    : occupancy 0..FIFO_DEPTH
module alt_vip_common_stream_output_fifo
  import alt_vip_common_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      entry0;
  logic [WIDTH-1:0]      entry1;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && (count_q < FIFO_CNT_W'(FIFO_DEPTH));

  // Shift-style storage: pops move entry1 forward so the head never moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0  <= '0;
      entry1  <= '0;
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b01: begin
          entry0  <= entry1;
          count_q <= count_q - FIFO_CNT_W'(1);
        end
        2'b10: begin
          if (count_q == '0) entry0 <= din;
          else               entry1 <= din;
          count_q <= count_q + FIFO_CNT_W'(1);
        end
        // Only reachable with one entry: the head leaves, the new word replaces it.
        2'b11: entry0 <= din;
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign count = count_q;

endmodule

// File: rtl/alt_vip_common_stream_output.sv
// Transmit-side VIP stream adapter: ready-latency-0 producer in, ready-latency-1
// Avalon-ST source out, with packet-boundary enable gating.
//   clk, rst : clock, async active-high reset
//   enable   : permits new packets (only looked at between packets)
//   synced   : idle between packets with nothing buffered
//   int_bus  : producer side (slave); ready derived from registers and enable
//   dout_bus : output side (master); valid/data/sop/eop registered
module alt_vip_common_stream_output
  import alt_vip_common_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic synced,
  alt_vip_common_stream_output_if.slave  int_bus,
  alt_vip_common_stream_output_if.master dout_bus
);

  localparam int unsigned WORD_W = DATA_WIDTH + 2;

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_next;
  logic                  ready_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  not_full_c;
  logic [FIFO_CNT_W-1:0] count;
  logic [WORD_W-1:0]     head;
  logic [WORD_W-1:0]     din;

  logic                  dout_valid_q;
  logic [DATA_WIDTH-1:0] dout_data_q;
  logic                  dout_sop_q;
  logic                  dout_eop_q;

  assign not_full_c = count < FIFO_CNT_W'(FIFO_DEPTH);
  assign accept_c   = int_bus.valid && ready_c;
  assign din        = {int_bus.data, int_bus.sop, int_bus.eop};
  assign pop_c      = dout_bus.ready && (count != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STATE_IDLE;
    else     state <= state_next;
  end

  // Next state, producer ready and push decision.
  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    push_c     = 1'b0;
    case (state)
      STATE_IDLE: begin
        ready_c = enable && not_full_c;
        // Words without sop are swallowed here to regain packet alignment.
        if (accept_c && int_bus.sop) begin
          push_c = 1'b1;
          if (!int_bus.eop) state_next = STATE_PACKET;
        end
      end
      STATE_PACKET: begin
        // A started packet always completes, regardless of enable.
        ready_c = not_full_c;
        if (accept_c) begin
          push_c = 1'b1;
          if (int_bus.eop) state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  alt_vip_common_stream_output_fifo #(
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // Output register: a word is loaded only when the sink was ready last cycle,
  // which gives ready latency 1. Payload holds when no transfer happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
    end else begin
      dout_valid_q <= pop_c;
      if (pop_c) begin
        dout_data_q <= head[WORD_W-1:2];
        dout_sop_q  <= head[1];
        dout_eop_q  <= head[0];
      end
    end
  end

  assign int_bus.ready  = ready_c;
  assign dout_bus.valid = dout_valid_q;
  assign dout_bus.data  = dout_data_q;
  assign dout_bus.sop   = dout_sop_q;
  assign dout_bus.eop   = dout_eop_q;
  assign synced         = (state == STATE_IDLE) && (count == '0);

endmodule

// File: tb/tb_alt_vip_common_stream_output.sv
// Bench for alt_vip_common_stream_output: directed packets checked against a
// queue-based behavioural model every cycle, plus literal output lists.
module tb_alt_vip_common_stream_output;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic synced;

  alt_vip_common_stream_output_if #(.DATA_WIDTH(10)) int_s ();
  alt_vip_common_stream_output_if #(.DATA_WIDTH(10)) dout_s ();

  alt_vip_common_stream_output #(.DATA_WIDTH(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .synced   (synced),
    .int_bus  (int_s),
    .dout_bus (dout_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: buffered words, packet-in-progress flag, expected dout.
  logic [11:0] mq[$];
  bit          in_pkt = 0;
  bit          exp_valid = 0;
  logic [11:0] exp_word = '0;
  bit          m_rdy, m_acc;
  bit          prev_ready = 0;

  // Captured output transfers and bookkeeping for the literal checks.
  logic [11:0] got[$];
  int          got_cyc[$];
  logic [11:0] exp_q[$];
  int          first_acc;
  int          stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) prev_ready = 0;
    else     prev_ready = dout_s.ready;
  end

  // Behavioural model, advanced at each active edge from pre-edge inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      in_pkt    = 0;
      exp_valid = 0;
      exp_word  = '0;
    end else begin
      m_rdy = (in_pkt || enable) && (mq.size() < 2);
      m_acc = int_s.valid && m_rdy;
      if (dout_s.ready && mq.size() > 0) begin
        exp_word  = mq.pop_front();
        exp_valid = 1;
      end else begin
        exp_valid = 0;
      end
      if (m_acc) begin
        if (in_pkt || int_s.sop) mq.push_back({int_s.data, int_s.sop, int_s.eop});
        in_pkt = in_pkt ? !int_s.eop : (int_s.sop && !int_s.eop);
      end
    end
  end

  // Per-cycle comparison against the model, plus transfer capture.
  always @(negedge clk) begin
    chk("int_ready", 32'(int_s.ready), 32'((in_pkt || enable) && mq.size() < 2));
    chk("synced", 32'(synced), 32'(!in_pkt && mq.size() == 0));
    chk("dout_valid", 32'(dout_s.valid), 32'(exp_valid));
    chk("dout_word", 32'({dout_s.data, dout_s.sop, dout_s.eop}), 32'(exp_word));
    if (dout_s.valid) begin
      chk("ready_latency", 32'(prev_ready), 32'd1);
      got.push_back({dout_s.data, dout_s.sop, dout_s.eop});
      got_cyc.push_back(cyc);
    end
    if (int_s.valid && !int_s.ready) stalls++;
  end

  task automatic send_word(input logic [9:0] d, input logic s, input logic e);
    int  n = 0;
    bit  acc = 0;
    int_s.valid = 1'b1;
    int_s.data  = d;
    int_s.sop   = s;
    int_s.eop   = e;
    while (!acc) begin
      @(negedge clk);
      acc = int_s.ready;
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    int_s.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(synced && !dout_s.valid) && n < 200);
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    first_acc = -1;
    stalls = 0;
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int_s.valid  = 1'b0;
    int_s.data   = '0;
    int_s.sop    = 1'b0;
    int_s.eop    = 1'b0;
    dout_s.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", 32'(dout_s.valid), 32'd0);
    chk("rst_dout_data", 32'(dout_s.data), 32'd0);
    chk("rst_dout_sop_eop", 32'({dout_s.sop, dout_s.eop}), 32'd0);
    chk("rst_synced", 32'(synced), 32'd1);
    chk("rst_int_ready_dis", 32'(int_s.ready), 32'd0);
    enable = 1'b1;
    #1;
    chk("rst_int_ready_en", 32'(int_s.ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back 4-word packet.
    start_test();
    dout_s.ready = 1'b1;
    send_word(10'h001, 1, 0);
    send_word(10'h002, 0, 0);
    send_word(10'h003, 0, 0);
    send_word(10'h004, 0, 1);
    wait_drain();
    exp_q = '{12'h006, 12'h008, 12'h00C, 12'h011};
    check_got("b2b");
    if (got_cyc.size() == 4) begin
      chk("b2b_latency", 32'(got_cyc[0] - first_acc), 32'd2);
      chk("b2b_consecutive", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
    end
    chk("b2b_synced", 32'(synced), 32'd1);

    // Output backpressure: dout_ready alternates 1,0.
    start_test();
    fork
      begin
        send_word(10'h101, 1, 0);
        for (int i = 2; i <= 5; i++) send_word(10'(10'h100 + i), 0, 0);
        send_word(10'h106, 0, 1);
      end
      begin
        for (int k = 0; k < 30; k++) begin
          dout_s.ready = (k % 2 == 0);
          @(posedge clk);
          #1;
        end
        dout_s.ready = 1'b1;
      end
    join
    wait_drain();
    exp_q = '{12'h406, 12'h408, 12'h40C, 12'h410, 12'h414, 12'h419};
    check_got("bp");
    chk("bp_stalled", 32'(stalls > 0), 32'd1);

    // Disable after word 2 of a 5-word packet.
    start_test();
    send_word(10'h201, 1, 0);
    send_word(10'h202, 0, 0);
    enable = 1'b0;
    send_word(10'h203, 0, 0);
    send_word(10'h204, 0, 0);
    send_word(10'h205, 0, 1);
    wait_drain();
    chk("dis_int_ready", 32'(int_s.ready), 32'd0);
    int_s.valid = 1'b1;
    int_s.data  = 10'h2A1;
    int_s.sop   = 1'b1;
    int_s.eop   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("dis_held_count", 32'(got.size()), 32'd5);
    chk("dis_held_synced", 32'(synced), 32'd1);
    enable = 1'b1;
    send_word(10'h2A1, 1, 0);
    send_word(10'h2A2, 0, 1);
    wait_drain();
    exp_q = '{12'h806, 12'h808, 12'h80C, 12'h810, 12'h815, 12'hA86, 12'hA89};
    check_got("dis");

    // Resync: words without sop are discarded in IDLE.
    start_test();
    send_word(10'h0A1, 0, 0);
    send_word(10'h0A2, 0, 0);
    send_word(10'h0A3, 0, 0);
    send_word(10'h010, 1, 0);
    send_word(10'h011, 0, 1);
    wait_drain();
    exp_q = '{12'h042, 12'h045};
    check_got("resync");

    // Reset with two words buffered.
    start_test();
    dout_s.ready = 1'b0;
    send_word(10'h301, 1, 0);
    send_word(10'h302, 0, 0);
    chk("mid_synced_before", 32'(synced), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(dout_s.valid), 32'd0);
    chk("mid_rst_data", 32'(dout_s.data), 32'd0);
    chk("mid_rst_synced", 32'(synced), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dout_s.ready = 1'b1;
    send_word(10'h320, 1, 0);
    send_word(10'h321, 0, 1);
    wait_drain();
    exp_q = '{12'hC82, 12'hC85};
    check_got("mid_rst");

    // Single-word packets stay in IDLE.
    start_test();
    send_word(10'h3FF, 1, 1);
    enable = 1'b0;
    #1;
    chk("single_idle", 32'(int_s.ready), 32'd0);
    enable = 1'b1;
    send_word(10'h000, 1, 1);
    wait_drain();
    exp_q = '{12'hFFF, 12'h003};
    check_got("single");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
